dmem_responder: RTL and testbench



---
 rtl/dmem_pkg.sv | 16 +
 rtl/dmem_array.sv | 32 +++
 rtl/dmem_responder.sv | 167 ++++++++++++++++
 tb/tb_dmem_responder.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared definitions for the data-memory responder.
//   state_e     : responder FSM encoding (ST_IDLE, ST_WAIT, ST_RESP)
//   WORD_BYTES  : bytes per memory word
//   CNT_W       : width of the latency down-counter (covers LATENCY up to 15)
package dmem_pkg;

  localparam int WORD_BYTES = 4;
  localparam int CNT_W      = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/dmem_array.sv
// dmem_array: word storage with synchronous write and a registered read.
// Ports:
//   clk_i  : clock, rising edge
//   we     : write enable, word at idx is written with wdata on the edge
//   idx    : word index
//   wdata  : write data
//   rdata  : contents of word idx as seen just before the most recent edge
// The array is not reset; contents survive a responder reset.
module dmem_array #(
  parameter int DEPTH  = 128,
  parameter int ADDR_W = 7
) (
  input  logic              clk_i,
  input  logic              we,
  input  logic [ADDR_W-1:0] idx,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] mem_q [DEPTH];
  logic [31:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we) begin
      mem_q[idx] <= wdata;
    end
    rdata_q <= mem_q[idx];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: responder side of the CPU data-memory interface.
// Accepts one load/store per req/ready handshake and answers with a
// one-cycle rvalid_o pulse LATENCY cycles after the acceptance edge.
// Ports:
//   clk_i, rst_i : clock (rising edge), async active-high reset
//   req_i, we_i  : request valid, 1 = store / 0 = load
//   addr_i       : byte address; word index is addr_i[ADDR_W+1:2]
//   wdata_i      : store data
//   ready_o      : request can be accepted this cycle
//   rvalid_o     : response pulse
//   rdata_o      : load data (0 for stores), valid while rvalid_o=1
//   err_o        : misaligned-access flag, only with DMEM_ALIGN_CHECK_EN
// Optional feature macro: DMEM_ALIGN_CHECK_EN
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | ready for a request
// ST_WAIT | request in flight, counting down latency, req_i ignored
// ST_RESP | rvalid_o high; a new request may be accepted back-to-back
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH   = 128,
  parameter int ADDR_W  = 7,
  parameter int LATENCY = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        ready_o,
  output logic        rvalid_o,
  output logic [31:0] rdata_o
`ifdef DMEM_ALIGN_CHECK_EN
  ,
  output logic        err_o
`endif
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ready_q, ready_d;
  logic               rvalid_q, rvalid_d;
  logic               load_q, load_d;
  logic               err_pend_q, err_pend_d;
  logic               err_q, err_d;
  logic [ADDR_W-1:0]  idx_q, idx_d;
  logic [31:0]        rdata_hold_q, rdata_hold_d;

  logic               accept;
  logic               misalign;
  logic [ADDR_W-1:0]  idx_in;
  logic               arr_we;
  logic [ADDR_W-1:0]  arr_idx;
  logic [31:0]        arr_rdata;
  logic [31:0]        rdata_mux;

  assign accept = req_i & ready_q;
  assign idx_in = addr_i[ADDR_W+1:2];

`ifdef DMEM_ALIGN_CHECK_EN
  assign misalign = (addr_i[1:0] != 2'b00);
  assign err_o    = err_q;
`else
  assign misalign = 1'b0;
`endif

  // Upper address bits wrap; low bits only matter with alignment checking.
  logic unused_ok;
  assign unused_ok = ^{addr_i[31:ADDR_W+2], addr_i[1:0], err_q};

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    load_d     = load_q;
    err_pend_d = err_pend_q;
    idx_d      = idx_q;
    arr_we     = 1'b0;
    // Holding the index keeps the array's registered read stable through WAIT.
    arr_idx    = idx_q;

    case (state_q)
      ST_WAIT: begin
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_RESP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        if (state_q == ST_RESP) begin
          state_d = ST_IDLE;
        end
        if (accept) begin
          idx_d      = idx_in;
          arr_idx    = idx_in;
          arr_we     = we_i & ~misalign;
          load_d     = ~we_i & ~misalign;
          err_pend_d = misalign;
          if (LATENCY == 1) begin
            state_d = ST_RESP;
            cnt_d   = '0;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = CNT_W'(LATENCY - 1);
          end
        end
      end
    endcase

    ready_d  = (state_d != ST_WAIT);
    rvalid_d = (state_d == ST_RESP);
    err_d    = (state_d == ST_RESP) & err_pend_d;

    // The array captured the word on the acceptance edge; present it only
    // in RESP and otherwise hold the previous output.
    if (state_q == ST_RESP) begin
      rdata_mux = load_q ? arr_rdata : 32'h0;
    end else begin
      rdata_mux = rdata_hold_q;
    end
    rdata_hold_d = rdata_mux;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      ready_q      <= 1'b1;
      rvalid_q     <= 1'b0;
      load_q       <= 1'b0;
      err_pend_q   <= 1'b0;
      err_q        <= 1'b0;
      idx_q        <= '0;
      rdata_hold_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ready_q      <= ready_d;
      rvalid_q     <= rvalid_d;
      load_q       <= load_d;
      err_pend_q   <= err_pend_d;
      err_q        <= err_d;
      idx_q        <= idx_d;
      rdata_hold_q <= rdata_hold_d;
    end
  end

  assign ready_o  = ready_q;
  assign rvalid_o = rvalid_q;
  assign rdata_o  = rdata_mux;

  dmem_array #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk_i (clk_i),
    .we    (arr_we),
    .idx   (arr_idx),
    .wdata (wdata_i),
    .rdata (arr_rdata)
  );

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: three responders with LATENCY 2, 1 and 4 share a clock
// and reset. Each accepted request pushes its expected data and response
// cycle to a scoreboard; a negedge monitor pops and compares on rvalid_o.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  req = '0;
  logic [2:0]  we  = '0;
  logic [31:0] addr  [3];
  logic [31:0] wdata [3];
  logic [2:0]  ready;
  logic [2:0]  rvalid;
  logic [31:0] rdata [3];
`ifdef DMEM_ALIGN_CHECK_EN
  logic [2:0]  err;
`endif

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  typedef struct {
    int          unit;
    logic [31:0] data;
    int          cyc;
    logic        err;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  dmem_responder #(.LATENCY(2)) u_dut0 (
    .clk_i(clk), .rst_i(rst), .req_i(req[0]), .we_i(we[0]),
    .addr_i(addr[0]), .wdata_i(wdata[0]), .ready_o(ready[0]),
    .rvalid_o(rvalid[0]), .rdata_o(rdata[0])
`ifdef DMEM_ALIGN_CHECK_EN
    , .err_o(err[0])
`endif
  );

  dmem_responder #(.LATENCY(1)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .req_i(req[1]), .we_i(we[1]),
    .addr_i(addr[1]), .wdata_i(wdata[1]), .ready_o(ready[1]),
    .rvalid_o(rvalid[1]), .rdata_o(rdata[1])
`ifdef DMEM_ALIGN_CHECK_EN
    , .err_o(err[1])
`endif
  );

  dmem_responder #(.LATENCY(4)) u_dut2 (
    .clk_i(clk), .rst_i(rst), .req_i(req[2]), .we_i(we[2]),
    .addr_i(addr[2]), .wdata_i(wdata[2]), .ready_o(ready[2]),
    .rvalid_o(rvalid[2]), .rdata_o(rdata[2])
`ifdef DMEM_ALIGN_CHECK_EN
    , .err_o(err[2])
`endif
  );

  function automatic int lat_of(int u);
    case (u)
      0:       return 2;
      1:       return 1;
      default: return 4;
    endcase
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    for (int u = 0; u < 3; u++) begin
      if (rvalid[u] !== 1'b0) begin
        if (sb.size() == 0) begin
          chk("unexpected_rvalid", {31'b0, rvalid[u]}, 32'h0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("resp_unit", u, e.unit);
          chk("rdata", rdata[u], e.data);
          chk("rvalid_cycle", cyc, e.cyc);
`ifdef DMEM_ALIGN_CHECK_EN
          chk("err_resp", {31'b0, err[u]}, {31'b0, e.err});
`endif
        end
      end
`ifdef DMEM_ALIGN_CHECK_EN
      else if (err[u] !== 1'b0) begin
        chk("err_idle", {31'b0, err[u]}, 32'h0);
      end
`endif
    end
  end

  // Waits for ready at a negedge, drives the request, returns #1 after the
  // acceptance edge. req stays high so callers can chain back-to-back.
  task automatic do_req(int u, logic w, logic [31:0] a, logic [31:0] d,
                        logic [31:0] exp_d, logic exp_e, bit track);
    int n;
    n = 0;
    @(negedge clk);
    while (ready[u] !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) chk("ready_timeout", {31'b0, ready[u]}, 32'h1);
    req[u]   = 1'b1;
    we[u]    = w;
    addr[u]  = a;
    wdata[u] = d;
    @(posedge clk);
    #1;
    if (track) sb.push_back('{unit: u, data: exp_d, cyc: cyc + lat_of(u) - 1, err: exp_e});
  endtask

  task automatic idle(int u);
    @(negedge clk);
    req[u] = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) chk("drain_timeout", sb.size(), 32'h0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      addr[i]  = '0;
      wdata[i] = '0;
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_ready", {29'b0, ready}, 32'h7);
    chk("rst_rvalid", {29'b0, rvalid}, 32'h0);
    for (int i = 0; i < 3; i++) chk("rst_rdata", rdata[i], 32'h0);
    rst = 1'b0;

    // LATENCY=2: store then load same word
    do_req(0, 1'b1, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 1'b1);
    do_req(0, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 1'b1);
    idle(0);
    drain();

    // LATENCY=1: preload, then three back-to-back loads
    do_req(1, 1'b1, 32'h0, 32'd1, 32'h0, 1'b0, 1'b1);
    do_req(1, 1'b1, 32'h4, 32'd2, 32'h0, 1'b0, 1'b1);
    do_req(1, 1'b1, 32'h8, 32'd3, 32'h0, 1'b0, 1'b1);
    idle(1);
    drain();
    for (int i = 0; i < 3; i++) begin
      do_req(1, 1'b0, 32'(i * 4), 32'h0, 32'(i + 1), 1'b0, 1'b1);
      chk("l1_ready_held", {31'b0, ready[1]}, 32'h1);
    end
    idle(1);
    drain();

    // LATENCY=4: inputs wiggle during WAIT, original address must win
    do_req(2, 1'b1, 32'h20, 32'h4444, 32'h0, 1'b0, 1'b1);
    do_req(2, 1'b1, 32'h24, 32'h9999, 32'h0, 1'b0, 1'b1);
    idle(2);
    drain();
    do_req(2, 1'b0, 32'h20, 32'h0, 32'h4444, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("l4_wait_ready", {31'b0, ready[2]}, 32'h0);
      req[2]  = ~req[2];
      addr[2] = 32'h24;
      we[2]   = k[0];
    end
    @(negedge clk);
    chk("l4_resp_ready", {31'b0, ready[2]}, 32'h1);
    req[2] = 1'b0;
    drain();

    // Address wrap-around on LATENCY=2
    do_req(0, 1'b1, 32'h200, 32'h55, 32'h0, 1'b0, 1'b1);
    do_req(0, 1'b0, 32'h0, 32'h0, 32'h55, 1'b0, 1'b1);
    idle(0);
    drain();

    // Reset during WAIT of a load: response discarded, committed data kept
    do_req(2, 1'b1, 32'h40, 32'hA5A50001, 32'h0, 1'b0, 1'b1);
    idle(2);
    drain();
    do_req(2, 1'b0, 32'h40, 32'h0, 32'h0, 1'b0, 1'b0);
    req[2] = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_mid_ready", {31'b0, ready[2]}, 32'h1);
    chk("rst_mid_rvalid", {31'b0, rvalid[2]}, 32'h0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    do_req(2, 1'b0, 32'h40, 32'h0, 32'hA5A50001, 1'b0, 1'b1);
    idle(2);
    drain();

`ifdef DMEM_ALIGN_CHECK_EN
    // Misaligned store is dropped; misaligned load returns 0
    do_req(0, 1'b1, 32'h12, 32'h1234, 32'h0, 1'b1, 1'b1);
    do_req(0, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 1'b1);
    do_req(0, 1'b0, 32'h13, 32'h0, 32'h0, 1'b1, 1'b1);
    idle(0);
    drain();
`endif

    chk("sb_empty", sb.size(), 32'h0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
